// File: rtl/pixel_stream_scrambler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pixel_scrambler_pkg                                          |
// | Description : Shared constants and the Fibonacci LFSR step function for   |
// |               the pixel stream scrambler.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pixel_scrambler_pkg;

  // Widest LFSR the step helper can serve; callers zero-extend into it.
  localparam int unsigned C_LFSR_MAX_W = 32;

  localparam logic [11:0] C_TAPS_DEFAULT     = 12'h829;
  localparam logic [11:0] C_KEY_SEED_DEFAULT = 12'hACE;
  localparam logic [11:0] C_CODE_RST_DEFAULT = 12'h001;

  // One Fibonacci step: parity of the tapped bits enters at the MSB of a
  // 'width'-bit register while everything shifts toward bit 0. Bits above
  // 'width' must be zero on entry and stay zero on exit.
  function automatic logic [C_LFSR_MAX_W-1:0] lfsr_step(
    input logic [C_LFSR_MAX_W-1:0] state,
    input logic [C_LFSR_MAX_W-1:0] taps,
    input int unsigned             width
  );
    logic [C_LFSR_MAX_W-1:0] fb_vec;
    fb_vec = {{(C_LFSR_MAX_W-1){1'b0}}, ^(state & taps)};
    return (state >> 1) | (fb_vec << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_stream_scrambler_lfsr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr_seq                                                     |
// | Description : Fibonacci LFSR register with synchronous reload (priority)  |
// |               and step enable.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lfsr_seq
  import pixel_scrambler_pkg::*;
#(
  parameter int unsigned      WIDTH   = 12,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(C_TAPS_DEFAULT),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(C_KEY_SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: reload wins over stepping, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = WIDTH'(lfsr_step(C_LFSR_MAX_W'(state_q), C_LFSR_MAX_W'(TAPS), WIDTH));
    end
  end

  // State register, asynchronously returned to the reset seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/pixel_stream_scrambler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_stream_scrambler                                       |
// | Description : XORs a valid/ready pixel stream with a key built from a     |
// |               fixed-seed LFSR and a user-coded LFSR, both reseeded on     |
// |               every accepted start-of-frame. One registered output stage. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pixel_stream_scrambler
  import pixel_scrambler_pkg::*;
#(
  parameter int unsigned       PIX_W    = 12,
  parameter int unsigned       LFSR_W   = 12,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(C_TAPS_DEFAULT),
  parameter logic [LFSR_W-1:0] KEY_SEED = LFSR_W'(C_KEY_SEED_DEFAULT),
  parameter logic [LFSR_W-1:0] CODE_RST = LFSR_W'(C_CODE_RST_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_enable,
  input  logic [LFSR_W-1:0] cfg_code,
  input  logic              cfg_code_load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [PIX_W-1:0]  out_data,
  output logic [15:0]       frame_cnt
);

  // The key LFSR always restarts from the same seed, so its post-sof value is fixed.
  localparam logic [LFSR_W-1:0] c_key_after_sof =
    LFSR_W'(lfsr_step(C_LFSR_MAX_W'(KEY_SEED), C_LFSR_MAX_W'(TAPS), LFSR_W));

  logic [LFSR_W-1:0] code_reg_q, code_reg_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sof_q, out_sof_d;
  logic [PIX_W-1:0]  out_data_q, out_data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic              w_accept;
  logic              w_sof_acc;
  logic [LFSR_W-1:0] w_key_state;
  logic [LFSR_W-1:0] w_code_state;
  logic [LFSR_W-1:0] w_code_after_sof;
  logic [LFSR_W-1:0] w_key_full;
  logic [PIX_W-1:0]  w_result;

  assign in_ready  = !out_valid_q | out_ready;
  assign w_accept  = in_valid & in_ready;
  assign w_sof_acc = w_accept & in_sof;

  // A sof beat keys from the seeds themselves, then leaves both LFSRs one step on.
  assign w_code_after_sof =
    LFSR_W'(lfsr_step(C_LFSR_MAX_W'(code_reg_q), C_LFSR_MAX_W'(TAPS), LFSR_W));

  lfsr_seq #(
    .WIDTH   (LFSR_W),
    .TAPS    (TAPS),
    .RST_VAL (KEY_SEED)
  ) u_key_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_sof_acc),
    .load_val (c_key_after_sof),
    .step     (w_accept),
    .state    (w_key_state)
  );

  lfsr_seq #(
    .WIDTH   (LFSR_W),
    .TAPS    (TAPS),
    .RST_VAL (CODE_RST)
  ) u_code_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_sof_acc),
    .load_val (w_code_after_sof),
    .step     (w_accept),
    .state    (w_code_state)
  );

  assign w_key_full = in_sof ? (KEY_SEED ^ code_reg_q) : (w_key_state ^ w_code_state);
  assign w_result   = cfg_enable ? (in_data ^ w_key_full[PIX_W-1:0]) : in_data;

  // Code latch; a zero code would lock the code LFSR, so it is replaced by 1.
  always_comb begin
    code_reg_d = code_reg_q;
    if (cfg_code_load) begin
      code_reg_d = (cfg_code == '0) ? LFSR_W'(1) : cfg_code;
    end
  end

  // Output stage: load on accept, drain when taken downstream, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_data_d  = out_data_q;
    frame_cnt_d = frame_cnt_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_sof_d   = in_sof;
      out_data_d  = w_result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_sof_acc) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // State registers; reset drops any in-flight output beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_reg_q  <= CODE_RST;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      code_reg_q  <= code_reg_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_scrambler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_stream_scrambler                                    |
// | Description : Self-checking bench: scrambler followed by a second instance |
// |               acting as descrambler, compared against a position-based    |
// |               reference model.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pixel_stream_scrambler;

  localparam int unsigned KEY_SEED = 32'hACE;
  localparam int unsigned TAPS     = 32'h829;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [11:0] cfg_code = 12'h0;
  logic        cfg_code_load = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [11:0] in_data = 12'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_sof;
  logic [11:0] out_data;
  logic [15:0] frame_cnt;

  logic        rx_in_valid, rx_in_ready, rx_out_valid, rx_out_sof;
  logic [11:0] rx_out_data;
  logic [15:0] rx_frame_cnt;

  assign rx_in_valid = out_valid & out_ready;

  always #5 clk = ~clk;

  pixel_stream_scrambler dut (
    .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_code(cfg_code),
    .cfg_code_load(cfg_code_load), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_data(out_data), .frame_cnt(frame_cnt)
  );

  pixel_stream_scrambler rx (
    .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_code(cfg_code),
    .cfg_code_load(cfg_code_load), .in_valid(rx_in_valid), .in_ready(rx_in_ready),
    .in_sof(out_sof), .in_data(out_data), .out_valid(rx_out_valid), .out_ready(1'b1),
    .out_sof(rx_out_sof), .out_data(rx_out_data), .frame_cnt(rx_frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the key depends only on the code of the current frame
  // and the beat position inside that frame.
  logic [11:0] m_code_reg, m_frame_code;
  int          m_pos, m_frames;
  logic [12:0] exp_q[$];
  logic [12:0] orig_q[$];
  logic        chain_on = 1'b0;

  // Observations from the latest cycle.
  logic        o_acc, o_fire, o_rdy, o_valid, o_sof;
  logic [11:0] o_data;
  logic [15:0] o_fcnt;
  logic        e_have, e_sof;
  logic [11:0] e_data;
  int          e_qsz, e_fcnt;
  logic        rx_fire, orig_have, orig_sof;
  logic [11:0] rx_data, orig_data;
  logic        rx_sof;

  function automatic logic [11:0] lfsr_adv(input logic [11:0] seed, input int n);
    int unsigned v;
    v = {20'h0, seed};
    for (int k = 0; k < n; k++) begin
      v = (v >> 1) | ((($countones(v & TAPS)) & 1) << 11);
    end
    return v[11:0];
  endfunction

  task automatic model_reset();
    m_code_reg   = 12'h001;
    m_frame_code = 12'h001;
    m_pos        = 0;
    m_frames     = 0;
    exp_q.delete();
    orig_q.delete();
  endtask

  // Drive one cycle, sample just after the falling edge, advance the model.
  task automatic step_cycle(input logic v, input logic s, input logic [11:0] d,
                            input logic en, input logic ordy, input logic ld,
                            input logic [11:0] code);
    logic [11:0] key;
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = d; cfg_enable = en;
    out_ready = ordy; cfg_code_load = ld; cfg_code = code;
    #1;
    o_acc = v && in_ready;
    o_fire = out_valid && out_ready;
    o_rdy = in_ready; o_valid = out_valid; o_data = out_data; o_sof = out_sof;
    o_fcnt = frame_cnt;
    e_fcnt = m_frames;
    e_qsz = exp_q.size();
    e_have = 1'b0; e_sof = 1'b0; e_data = 12'h0;
    if (o_fire && exp_q.size() > 0) begin
      {e_sof, e_data} = exp_q.pop_front();
      e_have = 1'b1;
    end
    rx_fire = rx_out_valid; rx_data = rx_out_data; rx_sof = rx_out_sof;
    orig_have = 1'b0; orig_sof = 1'b0; orig_data = 12'h0;
    if (chain_on && rx_fire && orig_q.size() > 0) begin
      {orig_sof, orig_data} = orig_q.pop_front();
      orig_have = 1'b1;
    end
    if (o_acc) begin
      if (s) begin
        m_frame_code = m_code_reg;
        m_pos = 0;
        m_frames = (m_frames + 1) % 65536;
      end
      key = lfsr_adv(KEY_SEED[11:0], m_pos) ^ lfsr_adv(m_frame_code, m_pos);
      exp_q.push_back({s, en ? (d ^ key) : d});
      if (chain_on) orig_q.push_back({s, d});
      m_pos++;
    end
    if (ld) m_code_reg = (code == 12'h0) ? 12'h001 : code;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 12'h0) begin errors++; $display("FAIL reset_out_data: got %h want 000", out_data); end
    checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_out_sof: got %b want 0", out_sof); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    step_cycle(0, 0, 12'h0, 1, 1, 1, 12'h000);
    step_cycle(1, 1, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_acc !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", o_acc); end
    step_cycle(1, 0, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_valid !== 1'b1 || o_data !== 12'hACF || o_sof !== 1'b1) begin
      errors++; $display("FAIL basic_beat0: got v=%b d=%h s=%b want v=1 d=acf s=1", o_valid, o_data, o_sof); end
    step_cycle(0, 0, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_valid !== 1'b1 || o_data !== 12'hD67 || o_sof !== 1'b0) begin
      errors++; $display("FAIL basic_beat1: got v=%b d=%h s=%b want v=1 d=d67 s=0", o_valid, o_data, o_sof); end
    step_cycle(0, 0, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got v=%b want 0", o_valid); end
  endtask

  task automatic test_stall();
    logic [11:0] held;
    logic        rdy;
    held = 12'h0;
    for (int i = 0; i < 27; i++) begin
      rdy = !(i >= 8 && i < 13);
      step_cycle(i < 24, i == 0, 12'($urandom), 1, rdy, 0, 12'h0);
      checks++; if (o_rdy !== (!o_valid || rdy)) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b want %b", i, o_rdy, !o_valid || rdy); end
      checks++; if (o_valid !== (e_qsz > 0)) begin errors++; $display("FAIL stall_out_valid: cycle %0d got %b want %b", i, o_valid, e_qsz > 0); end
      if (i == 8) held = o_data;
      if (i > 8 && i < 13) begin
        checks++; if (o_rdy !== 1'b0 || o_data !== held) begin
          errors++; $display("FAIL stall_hold: cycle %0d got rdy=%b d=%h want rdy=0 d=%h", i, o_rdy, o_data, held); end
      end
      if (o_fire) begin
        checks++; if (!e_have || o_data !== e_data || o_sof !== e_sof) begin
          errors++; $display("FAIL stall_beat: cycle %0d got d=%h s=%b want d=%h s=%b", i, o_data, o_sof, e_data, e_sof); end
      end
    end
  endtask

  task automatic test_enable();
    logic [11:0] din[10];
    int nfire;
    nfire = 0;
    for (int i = 0; i < 10; i++) din[i] = 12'($urandom);
    for (int i = 0; i < 12; i++) begin
      step_cycle(i < 10, i == 0, (i < 10) ? din[i] : 12'h0, !(i >= 1 && i <= 3), 1, 0, 12'h0);
      if (o_fire) begin
        checks++; if (!e_have || o_data !== e_data || o_sof !== e_sof) begin
          errors++; $display("FAIL enable_beat%0d: got d=%h s=%b want d=%h s=%b", nfire, o_data, o_sof, e_data, e_sof); end
        if (nfire >= 1 && nfire <= 3) begin
          checks++; if (o_data !== din[nfire]) begin
            errors++; $display("FAIL enable_bypass%0d: got %h want %h", nfire, o_data, din[nfire]); end
        end
        nfire++;
      end
    end
    checks++; if (nfire !== 10) begin errors++; $display("FAIL enable_count: got %0d want 10", nfire); end
  endtask

  task automatic test_code_load();
    int f0;
    int nfire;
    f0 = 0; nfire = 0;
    for (int i = 0; i < 12; i++) begin
      step_cycle(i <= 9, i == 0 || i == 9, (i == 0 || i == 9) ? 12'h0 : 12'($urandom), 1, 1,
                 i == 0 || i == 4, (i == 0) ? 12'h3C5 : 12'h123);
      if (i == 9) f0 = int'(o_fcnt);
      if (i == 10) begin
        checks++; if (int'(o_fcnt) !== (f0 + 1) % 65536) begin
          errors++; $display("FAIL code_frame_cnt: got %0d want %0d", o_fcnt, (f0 + 1) % 65536); end
      end
      if (o_fire) begin
        checks++; if (!e_have || o_data !== e_data || o_sof !== e_sof) begin
          errors++; $display("FAIL code_beat%0d: got d=%h s=%b want d=%h s=%b", nfire, o_data, o_sof, e_data, e_sof); end
        if (nfire == 0) begin
          checks++; if (o_data !== 12'hACF) begin errors++; $display("FAIL code_sof_old: got %h want acf", o_data); end
        end
        if (nfire == 9) begin
          checks++; if (o_data !== 12'hBED || o_sof !== 1'b1) begin
            errors++; $display("FAIL code_sof_new: got d=%h s=%b want d=bed s=1", o_data, o_sof); end
        end
        nfire++;
      end
    end
  endtask

  task automatic test_chain();
    int nrx;
    nrx = 0;
    repeat (3) step_cycle(0, 0, 12'h0, 1, 1, 0, 12'h0);
    chain_on = 1'b1;
    step_cycle(0, 0, 12'h0, 1, 1, 1, 12'h3C5);
    for (int i = 0; i < 644; i++) begin
      step_cycle(i < 640, i == 0, 12'($urandom), 1, 1, 0, 12'h0);
      if (o_fire) begin
        checks++; if (!e_have || o_data !== e_data || o_sof !== e_sof) begin
          errors++; $display("FAIL chain_tx: beat at cycle %0d got d=%h want d=%h", i, o_data, e_data); end
      end
      if (rx_fire) begin
        checks++; if (!orig_have || rx_data !== orig_data || rx_sof !== orig_sof) begin
          errors++; $display("FAIL chain_rx: beat %0d got d=%h s=%b want d=%h s=%b", nrx, rx_data, rx_sof, orig_data, orig_sof); end
        nrx++;
      end
    end
    checks++; if (nrx !== 640) begin errors++; $display("FAIL chain_count: got %0d want 640", nrx); end
    checks++; if (rx_in_ready !== 1'b1) begin errors++; $display("FAIL chain_rx_ready: got %b want 1", rx_in_ready); end
    checks++; if (int'(rx_frame_cnt) !== m_frames) begin errors++; $display("FAIL chain_rx_frames: got %0d want %0d", rx_frame_cnt, m_frames); end
    chain_on = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 420; i++) begin
      step_cycle(i < 400 && ($urandom % 4 != 0), ($urandom % 16) == 0, 12'($urandom),
                 1'($urandom), (i >= 400) || ($urandom % 4 != 0), ($urandom % 32) == 0,
                 ($urandom % 4 == 0) ? 12'h0 : 12'($urandom));
      checks++; if (o_valid !== (e_qsz > 0)) begin errors++; $display("FAIL rand_valid: cycle %0d got %b want %b", i, o_valid, e_qsz > 0); end
      checks++; if (int'(o_fcnt) !== e_fcnt) begin errors++; $display("FAIL rand_frame_cnt: cycle %0d got %0d want %0d", i, o_fcnt, e_fcnt); end
      if (o_fire) begin
        checks++; if (!e_have || o_data !== e_data || o_sof !== e_sof) begin
          errors++; $display("FAIL rand_beat: cycle %0d got d=%h s=%b want d=%h s=%b", i, o_data, o_sof, e_data, e_sof); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    step_cycle(1, 1, 12'($urandom), 1, 1, 0, 12'h0);
    step_cycle(1, 0, 12'($urandom), 1, 1, 0, 12'h0);
    step_cycle(1, 0, 12'($urandom), 1, 1, 0, 12'h0);
    step_cycle(0, 0, 12'h0, 1, 0, 0, 12'h0);
    checks++; if (o_valid !== 1'b1 || o_fcnt === 16'h0) begin
      errors++; $display("FAIL rstmid_pre: got v=%b fcnt=%h want v=1 fcnt!=0", o_valid, o_fcnt); end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || frame_cnt !== 16'h0 || out_data !== 12'h0) begin
      errors++; $display("FAIL rstmid_async: got v=%b fcnt=%h d=%h want v=0 fcnt=0000 d=000", out_valid, frame_cnt, out_data); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step_cycle(1, 1, 12'h0, 1, 1, 0, 12'h0);
    step_cycle(1, 0, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_valid !== 1'b1 || o_data !== 12'hACF || o_sof !== 1'b1) begin
      errors++; $display("FAIL rstmid_beat0: got v=%b d=%h s=%b want v=1 d=acf s=1", o_valid, o_data, o_sof); end
    step_cycle(0, 0, 12'h0, 1, 1, 0, 12'h0);
    checks++; if (o_valid !== 1'b1 || o_data !== 12'hD67) begin
      errors++; $display("FAIL rstmid_beat1: got v=%b d=%h want v=1 d=d67", o_valid, o_data); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_enable();
    test_code_load();
    test_chain();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_scrambler.md
Name: pixel_stream_scrambler

Overview:
Parametrised successor to the pixel XOR scrambler. Scrambles or descrambles a valid/ready pixel stream with two Fibonacci LFSRs: a fixed-seed key LFSR and a user-coded code LFSR. Both LFSRs are reseeded synchronously on a start-of-frame beat, so sender and receiver stay frame-aligned. Sits between the pixel source (frame buffer/pattern generator) and the VGA RGB port split, with a one-stage registered output.

Parameters:
PIX_W, 12, pixel width (XOR is symmetric, so one instance serves both scramble and descramble).
LFSR_W, 12, LFSR width; must satisfy LFSR_W >= PIX_W.
TAPS, 12'h829, feedback tap mask (bits 11,5,3,0).
KEY_SEED, 12'hACE, key LFSR reload value; must be non-zero.
CODE_RST, 12'h001, reset value of the latched code register.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_enable  in  1  1=scramble/descramble, 0=bypass
cfg_code  in  LFSR_W  code seed
cfg_code_load  in  1  pulse; latch cfg_code
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_sof  in  1  first pixel of frame, qualified by in_valid
in_data  in  PIX_W  input pixel
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_sof  out  1  sof aligned with out_data
out_data  out  PIX_W  scrambled pixel
frame_cnt  out  16  accepted sof count, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_sof=0, out_data=0, frame_cnt=0, key_lfsr=KEY_SEED, code_lfsr=CODE_RST, code_reg=CODE_RST.
- LFSR step: fb = ^(lfsr & TAPS); next = {fb, lfsr[LFSR_W-1:1]}. Applies to both LFSRs.
- code_reg: loads cfg_code on the cycle cfg_code_load=1. If cfg_code==0, it loads 1 instead (zero lock-up guard). The new code takes effect only at the next accepted sof, never mid-frame. If a load coincides with an accepted sof, that sof uses the old code_reg.
- Key per accepted beat:
  - sof beat: key = KEY_SEED ^ code_reg, truncated to PIX_W LSBs. After the beat, key_lfsr=step(KEY_SEED) and code_lfsr=step(code_reg).
  - Non-sof beat: key = key_lfsr ^ code_lfsr [PIX_W-1:0]. Both LFSRs then step.
- LFSRs hold when no beat is accepted. Bypass mode still steps them, so alignment is kept when enable toggles.
- Data: result = cfg_enable ? in_data ^ key : in_data. cfg_enable is sampled on the accepted beat.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - On an accepted beat the output register loads result/in_sof and out_valid=1 on the next edge, so latency is 1 cycle.
  - out_valid&out_ready with no new beat sets out_valid=0.
  - out_data/out_sof hold stable while out_valid&!out_ready.
  - Full throughput of 1 beat/cycle is required under continuous ready.
- A pre-sof stream after reset uses the reset LFSR state (key = KEY_SEED ^ CODE_RST on the first beat, then stepping).
- frame_cnt increments on each accepted sof.
- Reset mid-frame: everything returns to reset values immediately and any in-flight output beat is dropped.

Decomposition:
- Package pixel_scrambler_pkg: lfsr_step function (taps as argument) and default TAPS/KEY_SEED constants.
- Sub-module lfsr_seq (width/taps params; ports: clk, reset_n, load, load_val, step, state), instantiated twice: key and code.

Test Plan:
- Defaults, code load 0x000 (becomes 0x001), enable=1, sof beat 0x000 then beat 0x000 -> out 0xACF then 0xD67, each 1 cycle after acceptance.
- Two instances chained (scramble->descramble, same code 0x3C5), 640 random pixels with sof on the first -> receiver out_data equals original, out_sof aligned.
- out_ready held low 5 cycles mid-stream -> in_ready=0, out_data stable, LFSRs do not step; after release, sequence identical to the no-stall run.
- enable=0 for beats 2-4 of a frame -> those beats pass unmodified; beat 5 output equals the reference value for position 5 (LFSRs kept stepping).
- cfg_code_load 0x123 mid-frame -> remaining frame uses the old code; next sof beat 0x000 -> 0xACE^0x123=0xBED; frame_cnt increments by 1.
- Assert reset_n low with out_valid=1 mid-frame -> out_valid=0 and frame_cnt=0 immediately; next sof restarts from 0xACF-style values.
